// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage initiator for the 256x8 synchronous data memory.
// Takes one load/store per valid/ready handshake, drives registered strobes
// (WE, RE, A, WD) for exactly one cycle, and returns load data with its tag
// through a valid/ready response channel.
// Optional build macro MAU_STATS_EN: when defined, ld_count/st_count are
// live 8-bit wrapping counters; otherwise both are tied to zero.
module mem_access_unit #(
   parameter int TAG_W = 3
) (
   input  logic             Clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [7:0]       req_addr,
   input  logic [7:0]       req_wdata,
   input  logic [TAG_W-1:0] req_tag,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [7:0]       resp_data,
   output logic [TAG_W-1:0] resp_tag,
   output logic             WE,
   output logic             RE,
   output logic [7:0]       A,
   output logic [7:0]       WD,
   input  logic [7:0]       RD,
   output logic             stall,
   output logic [7:0]       ld_count,
   output logic [7:0]       st_count
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      CAPTURE,
      RESP
   } state_t;

   state_t             state_q, state_d;
   logic               we_q, we_d;
   logic               re_q, re_d;
   logic [7:0]         addr_q, addr_d;
   logic [7:0]         wdata_q, wdata_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic               respValid_q, respValid_d;
   logic [7:0]         respData_q, respData_d;
   logic [TAG_W-1:0]   respTag_q, respTag_d;

   // State and strobe registers; reset aborts any access in flight
   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         re_q        <= 1'b0;
         addr_q      <= 8'h00;
         wdata_q     <= 8'h00;
         tag_q       <= '0;
         respValid_q <= 1'b0;
         respData_q  <= 8'h00;
         respTag_q   <= '0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         re_q        <= re_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         tag_q       <= tag_d;
         respValid_q <= respValid_d;
         respData_q  <= respData_d;
         respTag_q   <= respTag_d;
      end
   end

   // Next-state logic: accept in IDLE, one-cycle strobe in ISSUE,
   // sample RD in CAPTURE, hold the response in RESP until taken
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      re_d        = re_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      tag_d       = tag_q;
      respValid_d = respValid_q;
      respData_d  = respData_q;
      respTag_d   = respTag_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               state_d = ISSUE;
               if (req_we) begin
                  we_d    = 1'b1;
                  re_d    = 1'b0;
                  wdata_d = req_wdata;
               end else begin
                  we_d  = 1'b0;
                  re_d  = 1'b1;
                  tag_d = req_tag;
               end
            end
         end
         ISSUE: begin
            if (we_q) begin
               we_d    = 1'b0;
               state_d = IDLE;
            end else begin
               re_d    = 1'b0;
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            respData_d  = RD;
            respTag_d   = tag_q;
            respValid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               respValid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign req_ready  = (state_q == IDLE);
   assign stall      = ~req_ready;
   assign WE         = we_q;
   assign RE         = re_q;
   assign A          = addr_q;
   assign WD         = wdata_q;
   assign resp_valid = respValid_q;
   assign resp_data  = respData_q;
   assign resp_tag   = respTag_q;

`ifdef MAU_STATS_EN
   logic [7:0] ldCount_q;
   logic [7:0] stCount_q;
   logic       stInc;
   logic       ldInc;

   assign stInc = (state_q == ISSUE) && we_q;
   assign ldInc = (state_q == RESP) && resp_ready;

   // Completed-access counters, wrapping at 8 bits
   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         ldCount_q <= 8'h00;
         stCount_q <= 8'h00;
      end else begin
         if (ldInc) ldCount_q <= ldCount_q + 8'd1;
         if (stInc) stCount_q <= stCount_q + 8'd1;
      end
   end

   assign ld_count = ldCount_q;
   assign st_count = stCount_q;
`else
   assign ld_count = 8'h00;
   assign st_count = 8'h00;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized self-checking bench for mem_access_unit.
// A behavioural 256x8 synchronous memory sits on the strobes; a separate
// transaction-level reference (refMem plus access counts) predicts results.
// Honours MAU_STATS_EN for the expected counter values.
module tb_mem_access_unit;

   localparam int TAG_W = 3;

   logic             Clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic             req_we = 1'b0;
   logic [7:0]       req_addr = 8'h00;
   logic [7:0]       req_wdata = 8'h00;
   logic [TAG_W-1:0] req_tag = '0;
   logic             resp_valid;
   logic             resp_ready = 1'b0;
   logic [7:0]       resp_data;
   logic [TAG_W-1:0] resp_tag;
   logic             WE, RE;
   logic [7:0]       A, WD;
   logic [7:0]       RD = 8'h00;
   logic             stall;
   logic [7:0]       ld_count, st_count;

   logic [7:0] mem    [256];
   logic [7:0] refMem [256];
   int  checks = 0;
   int  errors = 0;
   int  stCnt = 0;
   int  ldCnt = 0;
   bit  overlapSeen = 1'b0;

   mem_access_unit #(.TAG_W(TAG_W)) dut (
      .Clk(Clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_tag(resp_tag),
      .WE(WE), .RE(RE), .A(A), .WD(WD), .RD(RD),
      .stall(stall), .ld_count(ld_count), .st_count(st_count)
   );

   always #5 Clk = ~Clk;

   // Synchronous data memory: write on WE, read data appears after the RE edge
   always @(posedge Clk) begin
      if (WE) mem[A] <= WD;
      if (RE) RD <= mem[A];
   end

   // Strobe overlap monitor
   always @(negedge Clk) begin
      if (WE && RE) overlapSeen = 1'b1;
   end

   function automatic logic [7:0] expCount(int n);
      logic [7:0] v;
      v = 8'(n);
`ifndef MAU_STATS_EN
      v = 8'h00;
`endif
      return v;
   endfunction

   task automatic waitReady();
      int n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge Clk);
         n++;
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL wait_ready: req_ready=%b required 1", req_ready);
      end
   endtask

   task automatic doStore(input logic [7:0] addr, input logic [7:0] data);
      waitReady();
      req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = data;
      req_tag = TAG_W'($urandom);
      @(negedge Clk);
      req_valid = 1'b0; req_we = 1'($urandom); req_addr = 8'($urandom);
      req_wdata = 8'($urandom);
      checks++;
      if (WE !== 1'b1 || RE !== 1'b0 || A !== addr || WD !== data || stall !== 1'b1) begin
         errors++;
         $display("[TB] FAIL store_issue: WE=%b RE=%b A=%h WD=%h stall=%b required 1 0 %h %h 1",
                  WE, RE, A, WD, stall, addr, data);
      end
      @(negedge Clk);
      refMem[addr] = data;
      stCnt++;
      checks++;
      if (WE !== 1'b0 || req_ready !== 1'b1 || stall !== 1'b0 || st_count !== expCount(stCnt)) begin
         errors++;
         $display("[TB] FAIL store_done: WE=%b req_ready=%b stall=%b st_count=%0d required 0 1 0 %0d",
                  WE, req_ready, stall, st_count, expCount(stCnt));
      end
   endtask

   task automatic doLoad(input logic [7:0] addr, input logic [TAG_W-1:0] tag, input int delay);
      logic [7:0] expData;
      waitReady();
      resp_ready = 1'($urandom);
      req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_tag = tag;
      req_wdata = 8'($urandom);
      @(negedge Clk);
      req_valid = 1'b0;
      checks++;
      if (RE !== 1'b1 || WE !== 1'b0 || A !== addr || req_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL load_issue: RE=%b WE=%b A=%h req_ready=%b required 1 0 %h 0",
                  RE, WE, A, req_ready, addr);
      end
      resp_ready = 1'($urandom);
      @(negedge Clk);
      checks++;
      if (RE !== 1'b0 || resp_valid !== 1'b0 || stall !== 1'b1) begin
         errors++;
         $display("[TB] FAIL load_capture: RE=%b resp_valid=%b stall=%b required 0 0 1",
                  RE, resp_valid, stall);
      end
      resp_ready = 1'($urandom);
      @(negedge Clk);
      expData = refMem[addr];
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== expData || resp_tag !== tag) begin
         errors++;
         $display("[TB] FAIL load_resp: valid=%b data=%h tag=%0d required 1 %h %0d",
                  resp_valid, resp_data, resp_tag, expData, tag);
      end
      resp_ready = 1'b0;
      for (int i = 0; i < delay; i++) begin
         @(negedge Clk);
         checks++;
         if (resp_valid !== 1'b1 || resp_data !== expData || resp_tag !== tag ||
             stall !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_hold: valid=%b data=%h tag=%0d stall=%b ready=%b required 1 %h %0d 1 0",
                     resp_valid, resp_data, resp_tag, stall, req_ready, expData, tag);
         end
      end
      resp_ready = 1'b1;
      @(negedge Clk);
      resp_ready = 1'b0;
      ldCnt++;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || ld_count !== expCount(ldCnt)) begin
         errors++;
         $display("[TB] FAIL load_done: valid=%b req_ready=%b ld_count=%0d required 0 1 %0d",
                  resp_valid, req_ready, ld_count, expCount(ldCnt));
      end
   endtask

   task automatic checkIdleAfterReset(input string name);
      checks++;
      if (WE !== 1'b0 || RE !== 1'b0 || A !== 8'h00 || WD !== 8'h00 || resp_valid !== 1'b0 ||
          resp_data !== 8'h00 || resp_tag !== '0 || req_ready !== 1'b1 || stall !== 1'b0 ||
          ld_count !== 8'h00 || st_count !== 8'h00) begin
         errors++;
         $display("[TB] FAIL %s: WE=%b RE=%b A=%h WD=%h rv=%b rd=%h rt=%0d rdy=%b stall=%b ld=%0d st=%0d required all zero except rdy=1",
                  name, WE, RE, A, WD, resp_valid, resp_data, resp_tag, req_ready, stall, ld_count, st_count);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checkIdleAfterReset("reset_initial");
      @(negedge Clk);
      rst_n = 1'b1;
      @(negedge Clk);
      // Start a load and reset it while it sits in CAPTURE
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h22; req_tag = 3'd6;
      @(negedge Clk);
      req_valid = 1'b0;
      @(negedge Clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (WE !== 1'b0 || RE !== 1'b0 || resp_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_midload: WE=%b RE=%b resp_valid=%b required 0 0 0", WE, RE, resp_valid);
      end
      @(negedge Clk);
      rst_n = 1'b1;
      stCnt = 0;
      ldCnt = 0;
      @(negedge Clk);
      checkIdleAfterReset("reset_release");
      @(negedge Clk);
      checkIdleAfterReset("reset_quiet");
   endtask

   task automatic test_store_load();
      doStore(8'h3C, 8'hA5);
      doLoad(8'h3C, 3'd5, 0);
   endtask

   task automatic test_backpressure();
      doStore(8'h10, 8'h7E);
      doLoad(8'h10, 3'd2, 4);
   endtask

   task automatic test_held_request();
      int pulses = 0;
      logic prevWe = 1'b0;
      waitReady();
      req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h01; req_wdata = 8'h4D;
      for (int i = 0; i < 6; i++) begin
         @(negedge Clk);
         if (WE && !prevWe) pulses++;
         if (WE && (A !== 8'h01 || WD !== 8'h4D)) begin
            checks++;
            errors++;
            $display("[TB] FAIL held_strobe: A=%h WD=%h required 01 4d", A, WD);
         end
         prevWe = WE;
      end
      req_valid = 1'b0;
      @(negedge Clk);
      refMem[8'h01] = 8'h4D;
      stCnt += 3;
      checks++;
      if (pulses != 3 || WE !== 1'b0 || st_count !== expCount(stCnt)) begin
         errors++;
         $display("[TB] FAIL held_request: pulses=%0d WE=%b st_count=%0d required 3 0 %0d",
                  pulses, WE, st_count, expCount(stCnt));
      end
      doLoad(8'h01, 3'd1, 0);
   endtask

   task automatic test_addr_extremes();
      doStore(8'h00, 8'h5A);
      doStore(8'hFF, 8'hC3);
      doLoad(8'h00, 3'd0, 1);
      doLoad(8'hFF, 3'd7, 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         logic [7:0] addr;
         addr = 8'($urandom_range(0, 7)) + 8'h80;
         if ($urandom_range(0, 1) == 1) begin
            resp_ready = 1'($urandom);
            doStore(addr, 8'($urandom));
            resp_ready = 1'b0;
         end else begin
            doLoad(addr, TAG_W'($urandom), $urandom_range(0, 3));
         end
      end
   endtask

   task automatic test_wrap();
      rst_n = 1'b0;
      @(negedge Clk);
      rst_n = 1'b1;
      stCnt = 0;
      ldCnt = 0;
      @(negedge Clk);
      for (int i = 0; i < 256; i++) doStore(8'($urandom), 8'($urandom));
      checks++;
      if (st_count !== 8'h00) begin
         errors++;
         $display("[TB] FAIL wrap_st: st_count=%0d required 0", st_count);
      end
      for (int i = 0; i < 3; i++) doLoad(8'($urandom), TAG_W'(i), 0);
      checks++;
      if (ld_count !== expCount(3)) begin
         errors++;
         $display("[TB] FAIL wrap_ld: ld_count=%0d required %0d", ld_count, expCount(3));
      end
   endtask

   task automatic test_no_overlap();
      checks++;
      if (overlapSeen) begin
         errors++;
         $display("[TB] FAIL no_overlap: WE and RE seen high together, required never");
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]    = 8'($urandom);
         refMem[i] = mem[i];
      end
      #1;
      test_reset();
      test_store_load();
      test_backpressure();
      test_held_request();
      test_addr_extremes();
      test_random();
      test_wrap();
      test_no_overlap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
